// File: rtl/compare_pkg.sv
// compare_pkg: shared types and helpers for the compare_filter block.
//   cmp_mode_t      - compare select encoding (6/7 are reserved)
//   RESERVED_RESULT - result value driven for reserved mode codes
//   sel_result()    - maps gt/eq/lt flags to the selected mode's result
package compare_pkg;

  typedef enum logic [2:0] {
    CMP_GT = 3'd0,
    CMP_GE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_EQ = 3'd4,
    CMP_NE = 3'd5
  } cmp_mode_t;

  localparam logic RESERVED_RESULT = 1'b0;

  function automatic logic sel_result(input logic [2:0] mode, input logic gt,
                                      input logic eq, input logic lt);
    logic r;
    case (mode)
      CMP_GT:  r = gt;
      CMP_GE:  r = gt | eq;
      CMP_LT:  r = lt;
      CMP_LE:  r = lt | eq;
      CMP_EQ:  r = eq;
      CMP_NE:  r = ~eq;
      default: r = RESERVED_RESULT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/magnitude_cmp.sv
// magnitude_cmp: combinational magnitude comparator.
//   a, b : WIDTH-bit operands (two's complement when SIGNED != 0)
//   gt/eq/lt : exactly one is high
module magnitude_cmp #(
  parameter int WIDTH  = 10,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  import compare_pkg::*;

  logic [WIDTH:0] a_ext, b_ext, diff;

  // One extra bit holds any difference without overflow, so its MSB is
  // the borrow (unsigned) or the true sign (signed) of A-B.
  assign a_ext = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
  assign b_ext = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
  assign diff  = a_ext - b_ext;

  assign lt = diff[WIDTH];
  assign eq = (a == b);
  assign gt = ~lt & ~eq;

endmodule

// File: rtl/compare_filter.sv
// compare_filter: 2-stage pipelined comparator with debounce and hit counter.
//   clk, reset (async, active low)
//   in_valid, A, B, mode : sample input, registered in stage 1
//   clear                : sync clear of run counter, stable, hit_count
//   out_valid, result, a_gt_b, a_eq_b, a_lt_b : stage-2 outputs
//   stable               : high after STABLE_COUNT consecutive true results
//   hit_count            : saturating count of true valid results
module compare_filter #(
  parameter int WIDTH        = 10,
  parameter int SIGNED       = 0,
  parameter int STABLE_COUNT = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  output logic             result,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             stable,
  output logic [CNT_W-1:0] hit_count
);
  import compare_pkg::*;

  localparam int RUN_W = $clog2(STABLE_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  // vld_pipe_q[0]: stage-1 valid, vld_pipe_q[1]: out_valid
  logic [1:0]       vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       mode_q, mode_d;
  logic             result_q, result_d, gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic             stable_q, stable_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             gt_c, eq_c, lt_c, res_c;

  magnitude_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (
    .a  (a_q),
    .b  (b_q),
    .gt (gt_c),
    .eq (eq_c),
    .lt (lt_c)
  );

  assign res_c = sel_result(mode_q, gt_c, eq_c, lt_c);

  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], in_valid};
    a_d        = A;
    b_d        = B;
    mode_d     = mode;
    result_d   = result_q;
    gt_d       = gt_q;
    eq_d       = eq_q;
    lt_d       = lt_q;
    run_d      = run_q;
    stable_d   = stable_q;
    hit_d      = hit_q;

    // Flags hold across invalid cycles.
    if (vld_pipe_q[0]) begin
      result_d = res_c;
      gt_d     = gt_c;
      eq_d     = eq_c;
      lt_d     = lt_c;
    end

    // Filter state moves on the same edge that registers the result, so
    // stable rises/falls together with the qualifying result.
    if (clear) begin
      run_d    = '0;
      stable_d = 1'b0;
      hit_d    = '0;
    end else if (vld_pipe_q[0]) begin
      if (res_c) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        hit_d = (hit_q == HIT_MAX) ? hit_q : hit_q + 1'b1;
      end else begin
        run_d = '0;
      end
      stable_d = (run_d == RUN_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      result_q   <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      run_q      <= '0;
      stable_q   <= 1'b0;
      hit_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
      run_q      <= run_d;
      stable_q   <= stable_d;
      hit_q      <= hit_d;
    end
  end

  assign out_valid = vld_pipe_q[1];
  assign result    = result_q;
  assign a_gt_b    = gt_q;
  assign a_eq_b    = eq_q;
  assign a_lt_b    = lt_q;
  assign stable    = stable_q;
  assign hit_count = hit_q;

endmodule
